// File: rtl/uart_cfg_loader.sv
// uart_cfg_loader: 8N1 UART receiver that decodes (address, data) byte pairs
// and drives the synth cfg bus with a slow, fixed-length write strobe.
module uart_cfg_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STROBE_HOLD  = 8,
    parameter int unsigned DIV_BITS     = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] cfg_data,
    output logic [3:0] cfg_addr,
    output logic       cfg_strobe,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [DIV_BITS-1:0] HALF_RELOAD = DIV_BITS'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DIV_BITS-1:0] BIT_RELOAD  = DIV_BITS'(CLKS_PER_BIT - 1);
    localparam int unsigned         SEQ_BITS    = $clog2(2 * STROBE_HOLD);
    localparam logic [SEQ_BITS-1:0] HOLD_LAST   = SEQ_BITS'(STROBE_HOLD - 1);
    localparam logic [SEQ_BITS-1:0] SEQ_LAST    = SEQ_BITS'(2 * STROBE_HOLD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_ADDR, WAIT_DATA} parse_state_t;

    rx_state_t    rx_state, rx_state_nxt;
    parse_state_t p_state, p_state_nxt;

    logic                rx_m, rx_s;
    logic [DIV_BITS-1:0] bit_cnt;
    logic                cnt_zero;
    logic [2:0]          bit_idx;
    logic [7:0]          rx_byte;
    logic                byte_valid;

    logic ld_half, ld_bit, shift_en, clr_idx, stop_ok, stop_bad;

    logic [3:0]          addr_pending;
    logic                addr_latch, wr_start, drop;
    logic [SEQ_BITS-1:0] seq_cnt;

    assign cnt_zero = (bit_cnt == '0);

    // Two-flop synchroniser for the asynchronous rx pin (idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // RX FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= IDLE;
        else        rx_state <= rx_state_nxt;
    end

    // RX FSM next-state logic
    always_comb begin
        rx_state_nxt = rx_state;
        unique case (rx_state)
            IDLE:  if (!rx_s) rx_state_nxt = START;
            START: if (cnt_zero) rx_state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (cnt_zero && bit_idx == 3'd7) rx_state_nxt = STOP;
            STOP:  if (cnt_zero) rx_state_nxt = IDLE;
            default: rx_state_nxt = IDLE;
        endcase
    end

    // RX FSM control outputs: counter loads, shifting and stop-bit verdict
    always_comb begin
        ld_half  = 1'b0;
        ld_bit   = 1'b0;
        shift_en = 1'b0;
        clr_idx  = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (rx_state)
            IDLE:  ld_half = !rx_s;
            START: begin
                clr_idx = cnt_zero;
                ld_bit  = cnt_zero && !rx_s;
            end
            DATA: begin
                shift_en = cnt_zero;
                ld_bit   = cnt_zero;
            end
            STOP: begin
                stop_ok  = cnt_zero && rx_s;
                stop_bad = cnt_zero && !rx_s;
            end
            default: ;
        endcase
    end

    // Bit-timing down-counter, bit index, LSB-first shift register, RX pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (ld_half)       bit_cnt <= HALF_RELOAD;
            else if (ld_bit)   bit_cnt <= BIT_RELOAD;
            else if (!cnt_zero) bit_cnt <= bit_cnt - 1'b1;

            if (clr_idx)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 1'b1;

            if (shift_en) rx_byte <= {rx_s, rx_byte[7:1]};

            byte_valid <= stop_ok;
            frame_err  <= stop_bad;
        end
    end

    // Parser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_state <= WAIT_ADDR;
        else        p_state <= p_state_nxt;
    end

    // Parser next-state logic: bytes without bit7 are skipped while hunting an address
    always_comb begin
        p_state_nxt = p_state;
        unique case (p_state)
            WAIT_ADDR: if (byte_valid && rx_byte[7]) p_state_nxt = WAIT_DATA;
            WAIT_DATA: if (byte_valid) p_state_nxt = WAIT_ADDR;
            default:   p_state_nxt = WAIT_ADDR;
        endcase
    end

    // Parser outputs: address capture, write launch, or drop when busy
    always_comb begin
        addr_latch = (p_state == WAIT_ADDR) && byte_valid && rx_byte[7];
        wr_start   = (p_state == WAIT_DATA) && byte_valid && !busy;
        drop       = (p_state == WAIT_DATA) && byte_valid && busy;
    end

    // Pending address register and overrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_pending <= '0;
            overrun      <= 1'b0;
        end else begin
            if (addr_latch) addr_pending <= rx_byte[3:0];
            overrun <= drop;
        end
    end

    // Write sequencer: strobe high STROBE_HOLD cycles, low STROBE_HOLD, then idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_data   <= '0;
            cfg_addr   <= '0;
            cfg_strobe <= 1'b0;
            busy       <= 1'b0;
            seq_cnt    <= '0;
        end else if (wr_start) begin
            cfg_data   <= rx_byte;
            cfg_addr   <= addr_pending;
            cfg_strobe <= 1'b1;
            busy       <= 1'b1;
            seq_cnt    <= '0;
        end else if (busy) begin
            seq_cnt <= seq_cnt + 1'b1;
            if (seq_cnt == HOLD_LAST) cfg_strobe <= 1'b0;
            if (seq_cnt == SEQ_LAST)  busy       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_cfg_loader.sv
// Self-checking bench for uart_cfg_loader: two instances (short and long strobe),
// a timing-level reference model compared every cycle, plus literal spot checks.
module tb_uart_cfg_loader;

    localparam int C0 = 8;
    localparam int H0 = 4;
    localparam int C1 = 4;
    localparam int H1 = 50;

    typedef struct {
        int         s;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       rx_l   [2];
    logic [7:0] d_l    [2];
    logic [3:0] a_l    [2];
    logic       st_l   [2];
    logic       bz_l   [2];
    logic       fe_l   [2];
    logic       ov_l   [2];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // reference model state
    ev_t        q0[$];
    ev_t        q1[$];
    bit         m_wd   [2];
    logic [3:0] m_ap   [2];
    logic [7:0] m_data [2];
    logic [3:0] m_addr [2];
    bit         m_has  [2];
    int         m_ws   [2];
    bit         m_fe   [2];
    bit         m_ovr  [2];
    bit         m_st   [2];
    bit         m_bz   [2];

    // activity counters
    bit prev_st   [2];
    int rise_cnt  [2];
    int rise_edge [2];
    int hi_cnt    [2];
    int busy_cnt  [2];
    int fe_cnt    [2];
    int ovr_cnt   [2];

    uart_cfg_loader #(.CLKS_PER_BIT(C0), .STROBE_HOLD(H0), .DIV_BITS(9)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[0]),
        .cfg_data(d_l[0]), .cfg_addr(a_l[0]), .cfg_strobe(st_l[0]),
        .busy(bz_l[0]), .frame_err(fe_l[0]), .overrun(ov_l[0])
    );

    uart_cfg_loader #(.CLKS_PER_BIT(C1), .STROBE_HOLD(H1), .DIV_BITS(9)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[1]),
        .cfg_data(d_l[1]), .cfg_addr(a_l[1]), .cfg_strobe(st_l[1]),
        .busy(bz_l[1]), .frame_err(fe_l[1]), .overrun(ov_l[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int i);
        return (i == 0) ? C0 : C1;
    endfunction

    function automatic int hold(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h (t=%0t)", i, nm, act, exp, $time);
        end
    endtask

    task automatic pop_ev(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Model: a frame starting at edge p0 is judged at stop edge s; a good byte
    // reaches the parser one edge later; writes are timed from their start edge.
    task automatic model_step(input int i);
        ev_t e;
        bit  have;
        bit  busy_prev;
        int  n;
        n        = edge_n;
        m_fe[i]  = 1'b0;
        m_ovr[i] = 1'b0;
        if (!rst_n) begin
            if (i == 0) q0.delete(); else q1.delete();
            m_wd[i]   = 1'b0;
            m_ap[i]   = '0;
            m_data[i] = '0;
            m_addr[i] = '0;
            m_has[i]  = 1'b0;
            m_st[i]   = 1'b0;
            m_bz[i]   = 1'b0;
            return;
        end
        busy_prev = m_has[i] && ((n - 1 - m_ws[i]) < 2 * hold(i));
        have = 1'b0;
        if (i == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        if (have) begin
            if (!e.ok && e.s == n) begin
                m_fe[i] = 1'b1;
                pop_ev(i);
            end else if (e.ok && e.s + 1 == n) begin
                pop_ev(i);
                if (!m_wd[i]) begin
                    if (e.b[7]) begin
                        m_ap[i] = e.b[3:0];
                        m_wd[i] = 1'b1;
                    end
                end else begin
                    m_wd[i] = 1'b0;
                    if (busy_prev) m_ovr[i] = 1'b1;
                    else begin
                        m_has[i]  = 1'b1;
                        m_ws[i]   = n;
                        m_data[i] = e.b;
                        m_addr[i] = m_ap[i];
                    end
                end
            end
        end
        m_st[i] = m_has[i] && ((n - m_ws[i]) < hold(i));
        m_bz[i] = m_has[i] && ((n - m_ws[i]) < 2 * hold(i));
    endtask

    // Compare process: advance the model by the posedge just passed, check every output
    always @(negedge clk) begin
        edge_n = edge_n + 1;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            chk(i, "cfg_data",   32'(d_l[i]),  32'(m_data[i]));
            chk(i, "cfg_addr",   32'(a_l[i]),  32'(m_addr[i]));
            chk(i, "cfg_strobe", 32'(st_l[i]), 32'(m_st[i]));
            chk(i, "busy",       32'(bz_l[i]), 32'(m_bz[i]));
            chk(i, "frame_err",  32'(fe_l[i]), 32'(m_fe[i]));
            chk(i, "overrun",    32'(ov_l[i]), 32'(m_ovr[i]));
            if (st_l[i] === 1'b1 && !prev_st[i]) begin
                rise_cnt[i]++;
                rise_edge[i] = edge_n;
            end
            prev_st[i] = (st_l[i] === 1'b1);
            if (st_l[i] === 1'b1) hi_cnt[i]++;
            if (bz_l[i] === 1'b1) busy_cnt[i]++;
            if (fe_l[i] === 1'b1) fe_cnt[i]++;
            if (ov_l[i] === 1'b1) ovr_cnt[i]++;
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            rise_cnt[i] = 0;
            hi_cnt[i]   = 0;
            busy_cnt[i] = 0;
            fe_cnt[i]   = 0;
            ovr_cnt[i]  = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Send one 8N1 frame; rx changes 1 time unit after a falling clock edge
    task automatic send(input int i, input logic [7:0] b, input bit stop_ok, output int p0);
        ev_t e;
        int  c;
        c = cpb(i);
        @(negedge clk);
        #1;
        p0   = edge_n + 1;
        e.s  = p0 + 2 + c / 2 + 9 * c;
        e.b  = b;
        e.ok = stop_ok;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        rx_l[i] = 1'b0;
        repeat (c) @(negedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            rx_l[i] = b[k];
            repeat (c) @(negedge clk);
            #1;
        end
        rx_l[i] = stop_ok;
        repeat (c) @(negedge clk);
        #1;
        rx_l[i] = 1'b1;
    endtask

    initial begin
        int p;
        int pd;
        rst_n   = 1'b0;
        rx_l[0] = 1'b1;
        rx_l[1] = 1'b1;
        clear_counts();
        idle(3);
        chk(0, "reset_data",   32'(d_l[0]),  32'h0);
        chk(0, "reset_strobe", 32'(st_l[0]), 32'h0);
        chk(1, "reset_busy",   32'(bz_l[1]), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // 1: basic pair
        clear_counts();
        send(0, 8'h85, 1'b1, p);
        send(0, 8'h3C, 1'b1, pd);
        idle(20);
        chk(0, "t1_addr",      32'(a_l[0]), 32'h5);
        chk(0, "t1_data",      32'(d_l[0]), 32'h3C);
        chk(0, "t1_rises",     32'(rise_cnt[0]), 32'd1);
        chk(0, "t1_strobe_hi", 32'(hi_cnt[0]),   32'd4);
        chk(0, "t1_busy_len",  32'(busy_cnt[0]), 32'd8);
        chk(0, "t1_rise_edge", 32'(rise_edge[0]), 32'(pd + 79));

        // 2: non-address byte skipped
        clear_counts();
        send(0, 8'h12, 1'b1, p);
        send(0, 8'h80, 1'b1, p);
        send(0, 8'hFF, 1'b1, p);
        idle(20);
        chk(0, "t2_addr",  32'(a_l[0]), 32'h0);
        chk(0, "t2_data",  32'(d_l[0]), 32'hFF);
        chk(0, "t2_rises", 32'(rise_cnt[0]), 32'd1);

        // 3: byte with bit7 set accepted as data
        clear_counts();
        send(0, 8'h81, 1'b1, p);
        send(0, 8'h82, 1'b1, p);
        idle(20);
        chk(0, "t3_addr",  32'(a_l[0]), 32'h1);
        chk(0, "t3_data",  32'(d_l[0]), 32'h82);
        chk(0, "t3_rises", 32'(rise_cnt[0]), 32'd1);

        // 4: frame error between address and data
        clear_counts();
        send(0, 8'h87, 1'b1, p);
        send(0, 8'hC3, 1'b0, p);
        idle(20);
        send(0, 8'h55, 1'b1, p);
        idle(20);
        chk(0, "t4_frame_err", 32'(fe_cnt[0]), 32'd1);
        chk(0, "t4_addr",      32'(a_l[0]), 32'h7);
        chk(0, "t4_data",      32'(d_l[0]), 32'h55);
        chk(0, "t4_rises",     32'(rise_cnt[0]), 32'd1);

        // 5: false start (3-cycle glitch), then a good pair
        clear_counts();
        rx_l[0] = 1'b0;
        idle(3);
        rx_l[0] = 1'b1;
        idle(30);
        chk(0, "t5_glitch_fe",    32'(fe_cnt[0]),   32'd0);
        chk(0, "t5_glitch_rises", 32'(rise_cnt[0]), 32'd0);
        send(0, 8'h84, 1'b1, p);
        send(0, 8'h9A, 1'b1, p);
        idle(20);
        chk(0, "t5_addr",  32'(a_l[0]), 32'h4);
        chk(0, "t5_data",  32'(d_l[0]), 32'h9A);
        chk(0, "t5_rises", 32'(rise_cnt[0]), 32'd1);

        // 6: long strobe, second data byte arrives while busy
        clear_counts();
        send(1, 8'h82, 1'b1, p);
        send(1, 8'h11, 1'b1, p);
        send(1, 8'h83, 1'b1, p);
        send(1, 8'h22, 1'b1, p);
        idle(120);
        chk(1, "t6_data",    32'(d_l[1]), 32'h11);
        chk(1, "t6_addr",    32'(a_l[1]), 32'h2);
        chk(1, "t6_overrun", 32'(ovr_cnt[1]),  32'd1);
        chk(1, "t6_rises",   32'(rise_cnt[1]), 32'd1);
        chk(1, "t6_busy_len", 32'(busy_cnt[1]), 32'd100);

        // 7: asynchronous reset during the strobe-high phase
        clear_counts();
        send(0, 8'h86, 1'b1, p);
        send(0, 8'hE7, 1'b1, pd);
        repeat (2) @(negedge clk);
        #3;
        chk(0, "t7_pre_strobe", 32'(st_l[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk(0, "t7_async_strobe", 32'(st_l[0]), 32'h0);
        chk(0, "t7_async_busy",   32'(bz_l[0]), 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(30);
        chk(0, "t7_no_rise_after", 32'(rise_cnt[0]), 32'd1);
        send(0, 8'h8A, 1'b1, p);
        send(0, 8'h5A, 1'b1, p);
        idle(20);
        chk(0, "t7_addr",  32'(a_l[0]), 32'hA);
        chk(0, "t7_data",  32'(d_l[0]), 32'h5A);
        chk(0, "t7_rises", 32'(rise_cnt[0]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
